// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit arbiter.
// Rev 1.0
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_W            = 8;
  localparam int ARB_STATE_W            = 2;
  localparam int DEFAULT_LAUNCH_TIMEOUT = 16;

  typedef enum logic [ARB_STATE_W-1:0] {
    IDLE       = 2'd0,
    LAUNCH     = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// rr_arbiter: circular priority pick starting at a registered pointer; the
// pointer moves past the winner on update. Rev 1.0
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  output logic [ID_W-1:0]    winner,
  output logic               valid
);

  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  logic [ID_W-1:0] ptr;
  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;
  logic [ID_W:0]   nxt;

  // Walk from the farthest offset back to zero so the nearest valid index wins.
  always_comb begin
    winner = ptr;
    valid  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sum >= NUM_REQ_W) begin
        sum = sum - NUM_REQ_W;
      end
      idx = sum[ID_W-1:0];
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

  always_comb begin
    nxt = {1'b0, winner} + (ID_W+1)'(1);
    if (nxt == NUM_REQ_W) begin
      nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (update && valid) begin
      ptr <= nxt[ID_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART byte transmitter between
// NUM_REQ requesters, with launch watchdog and frame counter. Rev 1.0
`default_nettype none

module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int LAUNCH_TIMEOUT = DEFAULT_LAUNCH_TIMEOUT,
  parameter int CNT_W          = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*UART_DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic                           tx_wr_en,
  output logic [UART_DATA_W-1:0]         tx_din,
  input  logic                           tx_busy,
  output logic [ID_W-1:0]                grant_id,
  output logic                           arb_busy,
  output logic                           launch_err,
  output logic [CNT_W-1:0]               frame_cnt
);

  localparam int WD_W = $clog2(LAUNCH_TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(LAUNCH_TIMEOUT - 1);

  arb_state_e      state;
  logic [WD_W-1:0] wdog;
  logic [ID_W-1:0] pick;
  logic            pick_valid;
  logic            grant;

  // Arbitration only while idle and the transmitter is free, so a frame
  // still running after a reset blocks any new launch.
  assign grant    = (state == IDLE) && !tx_busy && pick_valid;
  assign arb_busy = (state != IDLE);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .update (grant),
    .winner (pick),
    .valid  (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ack    <= '0;
      tx_wr_en   <= 1'b0;
      tx_din     <= '0;
      grant_id   <= '0;
      launch_err <= 1'b0;
      frame_cnt  <= '0;
      wdog       <= '0;
    end else begin
      req_ack    <= '0;
      tx_wr_en   <= 1'b0;
      launch_err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            tx_din   <= req_data[{pick, 3'b000} +: UART_DATA_W];
            tx_wr_en <= 1'b1;
            req_ack  <= NUM_REQ'(1) << pick;
            grant_id <= pick;
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          wdog  <= '0;
          state <= WAIT_START;
        end
        WAIT_START: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (wdog == WD_LAST) begin
            launch_err <= 1'b1;
            state      <= IDLE;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a behavioural arbiter/transmitter
// model; a narrow frame counter is used so wrap-around is reached quickly.
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int ID_W = 2;
  localparam int T    = 16;
  localparam int CW   = 4;

  logic           clk       = 1'b0;
  logic           rst_n     = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*8-1:0] req_data  = '0;
  logic           tx_busy   = 1'b0;
  logic [N-1:0]   req_ack;
  logic           tx_wr_en;
  logic [7:0]     tx_din;
  logic [ID_W-1:0] grant_id;
  logic           arb_busy;
  logic           launch_err;
  logic [CW-1:0]  frame_cnt;

  uart_tx_arbiter #(
    .NUM_REQ (N), .ID_W (ID_W), .LAUNCH_TIMEOUT (T), .CNT_W (CW)
  ) dut (
    .clk (clk), .rst_n (rst_n), .req_valid (req_valid), .req_data (req_data),
    .req_ack (req_ack), .tx_wr_en (tx_wr_en), .tx_din (tx_din),
    .tx_busy (tx_busy), .grant_id (grant_id), .arb_busy (arb_busy),
    .launch_err (launch_err), .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0, checks = 0;
  int   cyc = 0, launch_cyc = 0;
  int   exp_err = 0;
  int   model_ptr = 0, model_fcnt = 0;
  int   force_len = 0;
  bit   stuck = 1'b0, txm_active = 1'b0;
  logic prev_busy = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // Reference rule: first pending requester at or after the pointer, circularly.
  function automatic int pick(input logic [N-1:0] p, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (p[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Transmitter model: busy after a short start delay for a random frame length.
  initial begin
    int dly, len;
    forever begin
      @(negedge clk);
      if (rst_n && tx_wr_en && !stuck) begin
        txm_active = 1'b1;
        dly = $urandom_range(0, 2);
        len = (force_len > 0) ? force_len : $urandom_range(2, 8);
        repeat (dly) @(negedge clk);
        tx_busy = 1'b1;
        repeat (len) @(negedge clk);
        tx_busy = 1'b0;
        txm_active = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT launches a byte.
  initial begin
    exp_t e;
    int   lat;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (tx_wr_en) begin
          launch_cyc = cyc;
          check("launch_while_busy", 32'(prev_busy), 0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_launch: got id %0d byte %0h expected no launch", grant_id, tx_din);
          end else begin
            e = exp_q.pop_front();
            check("grant_id", 32'(grant_id), e.id);
            check("tx_din", 32'(tx_din), 32'(e.data));
            check("req_ack", 32'(req_ack), 32'(1) << e.id);
          end
        end else if (req_ack != '0) begin
          check("ack_without_launch", 32'(req_ack), 0);
        end
        if (launch_err) begin
          lat = cyc - launch_cyc;
          check("launch_err_expected", 32'(exp_err > 0), 1);
          checks++;
          if (lat < T || lat > T + 1) begin
            errors++;
            $display("FAIL launch_err_latency: got %0d cycles expected %0d..%0d", lat, T, T + 1);
          end
          if (exp_err > 0) exp_err--;
        end
      end
      prev_busy = tx_busy;
    end
  end

  task automatic wait_idle();
    int t = 0;
    tick();
    while ((tx_busy || txm_active || arb_busy) && t < 300) begin
      tick();
      t++;
    end
    if (t >= 300) check("idle_timeout", 1, 0);
    tick();
  endtask

  task automatic wait_ack(output bit ok);
    int t = 0;
    while (req_ack == '0 && t < 100) begin
      tick();
      t++;
    end
    ok = (t < 100);
    if (!ok) check("ack_timeout", 1, 0);
  endtask

  // mode: 0 drop after ack, 1 random late adds, 2 stay valid, 3 add requester 3 in first frame.
  // dmode: 0 random bytes, 1 bytes 8'h10+i, 2 byte 8'hA5.
  task automatic run_round(input logic [N-1:0] mask, input int mode, input int max_g,
                           input int dmode, input bit count);
    logic [N-1:0] pend = mask;
    logic [N-1:0] addm;
    int  g = 0, w, t;
    bit  ok;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) req_data[i*8 +: 8] = (dmode == 1) ? 8'(8'h10 + i) :
                                         (dmode == 2) ? 8'hA5 : 8'($urandom);
    end
    req_valid = pend;
    while (pend != '0 && g < max_g) begin
      w = pick(pend, model_ptr);
      exp_q.push_back('{w, req_data[w*8 +: 8]});
      model_ptr = (w + 1) % N;
      g++;
      wait_ack(ok);
      if (!ok) break;
      if (mode != 2) begin
        pend[w] = 1'b0;
        req_valid = pend;
      end
      if (count) model_fcnt++;
      tick();
      if (mode == 1 || mode == 3) begin
        t = 0;
        while (!tx_busy && t < 20) begin
          tick();
          t++;
        end
        addm = (mode == 3) ? ((g == 1) ? 4'b1000 : 4'b0000) : N'($urandom) & ~pend;
        for (int i = 0; i < N; i++) begin
          if (addm[i]) req_data[i*8 +: 8] = 8'($urandom);
        end
        pend = pend | addm;
        req_valid = pend;
      end
    end
    req_valid = '0;
    wait_idle();
    check("frame_cnt", 32'(frame_cnt), model_fcnt % (1 << CW));
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ack", 32'(req_ack), 0);
    check("rst_tx_wr_en", 32'(tx_wr_en), 0);
    check("rst_tx_din", 32'(tx_din), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_launch_err", 32'(launch_err), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    check("rst_arb_busy", 32'(arb_busy), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    bit ok;
    tick();
    tick();
    check_reset_outputs();
    rst_n = 1'b1;
    tick();

    // All four continuously valid: 0,1,2,3,0.
    run_round(4'b1111, 2, 5, 1, 1'b1);
    // Single requester 2 with 8'hA5.
    run_round(4'b0100, 0, 8, 2, 1'b1);
    // Pointer to 1, then {0,1} with requester 3 arriving during 1's frame: 1,3,0.
    run_round(4'b0001, 0, 8, 0, 1'b1);
    run_round(4'b0011, 3, 8, 0, 1'b1);

    // Transmitter never starts: one watchdog error, count unchanged.
    stuck = 1'b1;
    exp_err = 1;
    run_round(4'b0010, 0, 8, 0, 1'b0);
    check("launch_err_seen", 32'(exp_err), 0);
    stuck = 1'b0;
    run_round(4'b0001, 0, 8, 0, 1'b1);

    // Reset while a long frame is in progress.
    force_len = 20;
    req_data[1*8 +: 8] = 8'h3C;
    exp_q.push_back('{pick(4'b0010, model_ptr), 8'h3C});
    req_valid = 4'b0010;
    wait_ack(ok);
    req_valid = '0;
    while (!tx_busy) tick();
    force_len = 0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check_reset_outputs();
    rst_n = 1'b1;
    model_ptr = 0;
    model_fcnt = 0;
    tick();
    tick();
    tick();
    check("tx_still_busy", 32'(tx_busy), 1);
    run_round(4'b0100, 0, 8, 0, 1'b1);

    // Randomised rounds.
    repeat (40) run_round(N'($urandom_range(1, 15)), $urandom_range(0, 1), 16, 0, 1'b1);

    // Drive the counter to its last value, then one more frame wraps it.
    while (model_fcnt % (1 << CW) != (1 << CW) - 1) run_round(4'b0001, 0, 1, 0, 1'b1);
    check("frame_cnt_max", 32'(frame_cnt), (1 << CW) - 1);
    run_round(4'b0010, 0, 1, 0, 1'b1);
    check("frame_cnt_wrap", 32'(frame_cnt), 0);

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
